// File: rtl/tb4004_pkg.sv
// Shared constants for the 4004-style fetch sequencer: cycle phases, opcodes,
// word-state encoding and the two-word opcode decode.
package tb4004_pkg;

  localparam int unsigned CYC_W  = 3;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PC_W   = 12;

  localparam logic [CYC_W-1:0] CYC_A1 = 3'd0;
  localparam logic [CYC_W-1:0] CYC_A2 = 3'd1;
  localparam logic [CYC_W-1:0] CYC_A3 = 3'd2;
  localparam logic [CYC_W-1:0] CYC_M1 = 3'd3;
  localparam logic [CYC_W-1:0] CYC_M2 = 3'd4;
  localparam logic [CYC_W-1:0] CYC_X1 = 3'd5;
  localparam logic [CYC_W-1:0] CYC_X2 = 3'd6;
  localparam logic [CYC_W-1:0] CYC_X3 = 3'd7;

  localparam logic [NIB_W-1:0] JCN = 4'h1;
  localparam logic [NIB_W-1:0] FIM = 4'h2;
  localparam logic [NIB_W-1:0] JUN = 4'h4;
  localparam logic [NIB_W-1:0] JMS = 4'h5;
  localparam logic [NIB_W-1:0] ISZ = 4'h7;

  typedef enum logic {
    WORD1 = 1'b0,
    WORD2 = 1'b1
  } fetch_state_e;

  // FIM with an odd operand is SRC, a one-word instruction.
  function automatic logic is_two_word(input logic [NIB_W-1:0] opr,
                                       input logic [NIB_W-1:0] opa);
    logic two;
    two = 1'b0;
    case (opr)
      JCN, JUN, JMS, ISZ: two = 1'b1;
      FIM:                two = ~opa[0];
      default:            two = 1'b0;
    endcase
    return two;
  endfunction

endpackage

// File: rtl/instr_fetch_seq_pc_counter.sv
// 12-bit program counter with load (priority) and wrapping increment.
module pc_counter
  import tb4004_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Eight-phase instruction fetch sequencer (A1..X3) with one/two-word decode.
// Build option FETCH_SEQ_STEP_EN: when defined, stepEn stalls the sequencer.
module instr_fetch_seq
  import tb4004_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stepEn,
  input  logic [NIB_W-1:0]  romData,
  input  logic              pcLoad,
  input  logic [PC_W-1:0]   pcLoadVal,
  output logic [CYC_W-1:0]  cycle,
  output logic              sync,
  output logic [NIB_W-1:0]  opr,
  output logic [NIB_W-1:0]  opa,
  output logic [BYTE_W-1:0] imm8,
  output logic              secondWord,
  output logic              instrValid,
  output logic [PC_W-1:0]   pc,
  output logic [NIB_W-1:0]  addrOut,
  output logic              addrOe
);

  logic step;

`ifdef FETCH_SEQ_STEP_EN
  assign step = stepEn;
`else
  logic unused_step_en;
  assign unused_step_en = stepEn;
  assign step           = 1'b1;
`endif

  fetch_state_e      state_q, state_d;
  logic [CYC_W-1:0]  cycle_q, cycle_d;
  logic [NIB_W-1:0]  opr_q, opr_d;
  logic [NIB_W-1:0]  opa_q, opa_d;
  logic [BYTE_W-1:0] imm8_q, imm8_d;
  logic              natural_w2;

  // Word-2 decision ignores pcLoad so a jump never suppresses instrValid.
  assign natural_w2 = (state_q == WORD1) && is_two_word(opr_q, opa_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WORD1;
      cycle_q <= CYC_A1;
      opr_q   <= '0;
      opa_q   <= '0;
      imm8_q  <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      imm8_q  <= imm8_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    opr_d   = opr_q;
    opa_d   = opa_q;
    imm8_d  = imm8_q;
    if (step) begin
      cycle_d = cycle_q + CYC_W'(1);
      case (cycle_q)
        CYC_M1: begin
          if (state_q == WORD2) imm8_d[7:4] = romData;
          else                  opr_d       = romData;
        end
        CYC_M2: begin
          if (state_q == WORD2) imm8_d[3:0] = romData;
          else                  opa_d       = romData;
        end
        CYC_X3: begin
          state_d = (natural_w2 && !pcLoad) ? WORD2 : WORD1;
        end
        default: ;
      endcase
    end
  end

  pc_counter u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (step && (cycle_q == CYC_M2)),
    .load_en  (step && (cycle_q == CYC_X3) && pcLoad),
    .load_val (pcLoadVal),
    .pc       (pc)
  );

  always_comb begin
    addrOut = '0;
    case (cycle_q)
      CYC_A1:  addrOut = pc[3:0];
      CYC_A2:  addrOut = pc[7:4];
      CYC_A3:  addrOut = pc[11:8];
      default: addrOut = '0;
    endcase
  end

  assign addrOe     = (cycle_q == CYC_A1) || (cycle_q == CYC_A2) || (cycle_q == CYC_A3);
  assign sync       = (cycle_q == CYC_X3);
  assign instrValid = sync && !natural_w2;
  assign secondWord = (state_q == WORD2);
  assign cycle      = cycle_q;
  assign opr        = opr_q;
  assign opa        = opa_q;
  assign imm8       = imm8_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboarded bench for instr_fetch_seq; reference model tracks expected outputs.
module tb_instr_fetch_seq;

  logic        clk;
  logic        rst;
  logic        stepEn;
  logic [3:0]  romData;
  logic        pcLoad;
  logic [11:0] pcLoadVal;
  logic [2:0]  cycle;
  logic        sync;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [7:0]  imm8;
  logic        secondWord;
  logic        instrValid;
  logic [11:0] pc;
  logic [3:0]  addrOut;
  logic        addrOe;

  instr_fetch_seq dut (
    .clk        (clk),
    .rst        (rst),
    .stepEn     (stepEn),
    .romData    (romData),
    .pcLoad     (pcLoad),
    .pcLoadVal  (pcLoadVal),
    .cycle      (cycle),
    .sync       (sync),
    .opr        (opr),
    .opa        (opa),
    .imm8       (imm8),
    .secondWord (secondWord),
    .instrValid (instrValid),
    .pc         (pc),
    .addrOut    (addrOut),
    .addrOe     (addrOe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cyc;
    logic [11:0] pc;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [7:0]  imm;
    logic        sw;
    logic        iv;
    logic        sync;
    logic        oe;
    logic [3:0]  ao;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [2:0]  m_cycle;
  logic [11:0] m_pc;
  logic [3:0]  m_opr;
  logic [3:0]  m_opa;
  logic [7:0]  m_imm;
  logic        m_w2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_two(input logic [3:0] o, input logic [3:0] a);
    return (o == 4'h1) || (o == 4'h4) || (o == 4'h5) || (o == 4'h7) ||
           ((o == 4'h2) && (a[0] == 1'b0));
  endfunction

  task automatic model_reset();
    m_cycle = 3'd0;
    m_pc    = 12'h000;
    m_opr   = 4'h0;
    m_opa   = 4'h0;
    m_imm   = 8'h00;
    m_w2    = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] rom,
                            input logic ld, input logic [11:0] ldv);
    logic go;
    logic nw;
`ifdef FETCH_SEQ_STEP_EN
    go = en;
`else
    go = 1'b1 | en;
`endif
    if (go) begin
      if (m_cycle == 3'd3) begin
        if (m_w2) m_imm[7:4] = rom;
        else      m_opr      = rom;
      end else if (m_cycle == 3'd4) begin
        if (m_w2) m_imm[3:0] = rom;
        else      m_opa      = rom;
        m_pc = m_pc + 12'h001;
      end else if (m_cycle == 3'd7) begin
        nw = !m_w2 && m_two(m_opr, m_opa);
        if (ld) begin
          m_pc = ldv;
          nw   = 1'b0;
        end
        m_w2 = nw;
      end
      m_cycle = m_cycle + 3'd1;
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.cyc  = m_cycle;
    e.pc   = m_pc;
    e.opr  = m_opr;
    e.opa  = m_opa;
    e.imm  = m_imm;
    e.sw   = m_w2;
    e.sync = (m_cycle == 3'd7);
    e.iv   = e.sync && !(!m_w2 && m_two(m_opr, m_opa));
    e.oe   = (m_cycle < 3'd3);
    e.ao   = (m_cycle == 3'd0) ? m_pc[3:0] :
             (m_cycle == 3'd1) ? m_pc[7:4] :
             (m_cycle == 3'd2) ? m_pc[11:8] : 4'h0;
    return e;
  endfunction

  task automatic compare_outputs(input exp_t e);
    chk("cycle", 32'(cycle), 32'(e.cyc));
    chk("pc", 32'(pc), 32'(e.pc));
    chk("opr", 32'(opr), 32'(e.opr));
    chk("opa", 32'(opa), 32'(e.opa));
    chk("imm8", 32'(imm8), 32'(e.imm));
    chk("secondWord", 32'(secondWord), 32'(e.sw));
    chk("instrValid", 32'(instrValid), 32'(e.iv));
    chk("sync", 32'(sync), 32'(e.sync));
    chk("addrOe", 32'(addrOe), 32'(e.oe));
    chk("addrOut", 32'(addrOut), 32'(e.ao));
  endtask

  // Drive one phase, predict its effect, clock, then compare the popped prediction.
  task automatic tick(input logic en, input logic [3:0] rom,
                      input logic ld, input logic [11:0] ldv);
    exp_t e;
    stepEn    = en;
    romData   = rom;
    pcLoad    = ld;
    pcLoadVal = ldv;
    model_step(en, rom, ld, ldv);
    sb.push_back(model_exp());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare_outputs(e);
  endtask

  // One full A1..X3 word starting from A1.
  task automatic fetch_word(input logic [3:0] n1, input logic [3:0] n2,
                            input logic ld_x1, input logic ld_x3, input logic [11:0] ldv,
                            output logic iv, output logic sw, output logic [11:0] addr);
    logic [3:0] rom;
    iv   = 1'b0;
    sw   = secondWord;
    addr = 12'h000;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) addr[4*i +: 4] = addrOut;
      if (i == 7) iv = instrValid;
      rom = (i == 3) ? n1 : (i == 4) ? n2 : 4'($urandom);
      tick(1'b1, rom, ((i == 5) && ld_x1) || ((i == 7) && ld_x3), ldv);
    end
  endtask

  logic        iv, sw;
  logic [11:0] addr;
  logic [11:0] pc0;
  logic [3:0]  opr0;

  initial begin
    rst = 1'b1; stepEn = 1'b1; romData = 4'h0; pcLoad = 1'b0; pcLoadVal = 12'h000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cycle", 32'(cycle), 32'd0);
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_secondWord", 32'(secondWord), 32'd0);
    chk("rst_instrValid", 32'(instrValid), 32'd0);
    chk("rst_addrOut", 32'(addrOut), 32'd0);
    chk("rst_addrOe", 32'(addrOe), 32'd1);
    chk("rst_opr", 32'(opr), 32'd0);
    rst = 1'b0;

    // LDM 5
    fetch_word(4'hD, 4'h5, 1'b0, 1'b0, 12'h000, iv, sw, addr);
    chk("ldm_iv", 32'(iv), 32'd1);
    chk("ldm_sw", 32'(sw), 32'd0);
    chk("ldm_addr", 32'(addr), 32'h000);
    chk("ldm_opr", 32'(opr), 32'hD);
    chk("ldm_opa", 32'(opa), 32'h5);
    chk("ldm_pc", 32'(pc), 32'h001);

    // JUN 0x123 with the jump taken in the second X3
    fetch_word(4'h4, 4'h1, 1'b0, 1'b0, 12'h000, iv, sw, addr);
    chk("jun1_iv", 32'(iv), 32'd0);
    chk("jun1_sw", 32'(sw), 32'd0);
    chk("jun_sw_after1", 32'(secondWord), 32'd1);
    fetch_word(4'h2, 4'h3, 1'b0, 1'b1, 12'h123, iv, sw, addr);
    chk("jun2_iv", 32'(iv), 32'd1);
    chk("jun2_sw", 32'(sw), 32'd1);
    chk("jun_imm8", 32'(imm8), 32'h23);
    chk("jun_opr_held", 32'(opr), 32'h4);
    chk("jun_pc", 32'(pc), 32'h123);
    fetch_word(4'hD, 4'h0, 1'b0, 1'b0, 12'h000, iv, sw, addr);
    chk("jun_target_addr", 32'(addr), 32'h123);
    chk("jun_target_sw", 32'(sw), 32'd0);

    // PC wrap
    fetch_word(4'hD, 4'h0, 1'b0, 1'b1, 12'hFFF, iv, sw, addr);
    chk("preset_pc", 32'(pc), 32'hFFF);
    fetch_word(4'hD, 4'h1, 1'b0, 1'b0, 12'h000, iv, sw, addr);
    chk("wrap_addr", 32'(addr), 32'hFFF);
    chk("wrap_pc", 32'(pc), 32'h000);

    // Stall at M1
    for (int i = 0; i < 3; i++) tick(1'b1, 4'hD, 1'b0, 12'h000);
    chk("stall_start", 32'(cycle), 32'd3);
    pc0  = pc;
    opr0 = opr;
    for (int i = 0; i < 5; i++) tick(1'b0, 4'hA, 1'b0, 12'h000);
`ifdef FETCH_SEQ_STEP_EN
    chk("stall_cycle", 32'(cycle), 32'd3);
    chk("stall_pc", 32'(pc), 32'(pc0));
    chk("stall_opr", 32'(opr), 32'(opr0));
`else
    chk("nostall_cycle", 32'(cycle), 32'd0);
    chk("nostall_pc", 32'(pc), 32'(pc0 + 12'h001));
`endif
    for (int i = 0; i < 8; i++) begin
      if (m_cycle != 3'd0) tick(1'b1, 4'hD, 1'b0, 12'h000);
    end
    chk("realign", 32'(cycle), 32'd0);

    // pcLoad in X1 ignored
    pc0 = pc;
    fetch_word(4'hD, 4'h2, 1'b1, 1'b0, 12'hABC, iv, sw, addr);
    chk("x1_load_ignored", 32'(pc), 32'(pc0 + 12'h001));

    // FIM odd (SRC) is one word; FIM even is two words
    fetch_word(4'h2, 4'h3, 1'b0, 1'b0, 12'h000, iv, sw, addr);
    chk("src_iv", 32'(iv), 32'd1);
    chk("src_next_sw", 32'(secondWord), 32'd0);
    fetch_word(4'h2, 4'h2, 1'b0, 1'b0, 12'h000, iv, sw, addr);
    chk("fim_iv", 32'(iv), 32'd0);
    fetch_word(4'h5, 4'h6, 1'b0, 1'b0, 12'h000, iv, sw, addr);
    chk("fim2_sw", 32'(sw), 32'd1);
    chk("fim2_iv", 32'(iv), 32'd1);
    chk("fim2_imm8", 32'(imm8), 32'h56);

    // Reset during WORD2 X1
    fetch_word(4'h4, 4'h0, 1'b0, 1'b0, 12'h000, iv, sw, addr);
    for (int i = 0; i < 5; i++) tick(1'b1, 4'h7, 1'b0, 12'h000);
    chk("pre_rst_sw", 32'(secondWord), 32'd1);
    chk("pre_rst_cycle", 32'(cycle), 32'd5);
    #1 rst = 1'b1;
    #1;
    chk("midrst_cycle", 32'(cycle), 32'd0);
    chk("midrst_pc", 32'(pc), 32'h000);
    chk("midrst_sw", 32'(secondWord), 32'd0);
    chk("midrst_addrOe", 32'(addrOe), 32'd1);
    model_reset();
    #1 rst = 1'b0;
    fetch_word(4'hD, 4'h0, 1'b0, 1'b0, 12'h000, iv, sw, addr);
    chk("postrst_addr", 32'(addr), 32'h000);
    chk("postrst_sw", 32'(sw), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 4) != 0), 4'($urandom), ($urandom_range(0, 3) == 0),
           12'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
